// File: rtl/icache_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_burst_reader_if
// Description : Burst request channel from the instruction cache plus the
//               single-word pipelined memory read channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_burst_reader_if;
  // Cache-side burst request / return
  logic        req_request;
  logic [29:0] req_addr;
  logic [4:0]  req_rlen;
  logic        req_ack;
  logic        req_rvalid;
  logic [31:0] req_rdata;
  // Memory-side single-word reads
  logic        mem_read;
  logic [29:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  // Burst reader's view
  modport slave (
    input  req_request, req_addr, req_rlen, mem_ready, mem_rvalid, mem_rdata,
    output req_ack, req_rvalid, req_rdata, mem_read, mem_addr
  );

  // Surrounding system's view (cache requester plus memory)
  modport master (
    output req_request, req_addr, req_rlen, mem_ready, mem_rvalid, mem_rdata,
    input  req_ack, req_rvalid, req_rdata, mem_read, mem_addr
  );
endinterface
`default_nettype wire

// File: rtl/icache_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : icache_burst_reader
// Description : Line-fill read engine. Accepts one burst request, issues it
//               as pipelined single-word reads starting at offset 0 of the
//               aligned line, bounds the reads in flight and returns the
//               words to the cache in line order.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_burst_reader #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int OUTSTANDING_W   = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  icache_burst_reader_if.slave        bus,
  output logic                        busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [OUTSTANDING_W-1:0] MAX_CNT = OUTSTANDING_W'(MAX_OUTSTANDING);
  localparam logic [OUTSTANDING_W-1:0] ONE_CNT = OUTSTANDING_W'(1);

  state_t                   state;
  logic [29:0]              base;
  logic [4:0]               last_idx;
  logic [4:0]               issue_idx;
  logic [4:0]               recv_idx;
  logic                     issue_done;
  logic [OUTSTANDING_W-1:0] outstanding;
  logic                     rvalid_q;
  logic [31:0]              rdata_q;

  logic                     in_burst;
  logic                     accept;

  assign in_burst       = (state == BURST);
  // Ack is only gated by state so a new request can be taken in the very
  // cycle the previous burst's final word is presented.
  assign bus.req_ack    = (state == IDLE) & bus.req_request;
  assign bus.mem_read   = in_burst & ~issue_done & (outstanding < MAX_CNT);
  // Line offset bits of base are zero, so OR-ing the index walks the line.
  assign bus.mem_addr   = in_burst ? (base | {25'b0, issue_idx}) : 30'b0;
  assign accept         = bus.mem_read & bus.mem_ready;
  assign bus.req_rvalid = rvalid_q;
  assign bus.req_rdata  = rdata_q;
  assign busy           = in_burst;

  // FSM, issue/return indices, in-flight count and registered return path
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base        <= '0;
      last_idx    <= '0;
      issue_idx   <= '0;
      recv_idx    <= '0;
      issue_done  <= 1'b0;
      outstanding <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_request) begin
            base        <= bus.req_addr & ~{25'b0, bus.req_rlen};
            last_idx    <= bus.req_rlen;
            issue_idx   <= '0;
            recv_idx    <= '0;
            issue_done  <= 1'b0;
            outstanding <= '0;
            state       <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            issue_idx <= issue_idx + 5'd1;
            if (issue_idx == last_idx) begin
              issue_done <= 1'b1;
            end
          end
          if (bus.mem_rvalid) begin
            rdata_q  <= bus.mem_rdata;
            rvalid_q <= 1'b1;
            recv_idx <= recv_idx + 5'd1;
            if (recv_idx == last_idx) begin
              state <= IDLE;
            end
          end
          // Simultaneous accept and return leave the count unchanged.
          if (accept && !bus.mem_rvalid) begin
            outstanding <= outstanding + ONE_CNT;
          end else if (!accept && bus.mem_rvalid && (outstanding != '0)) begin
            outstanding <= outstanding - ONE_CNT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Returned data with no burst in progress is dropped; flag it.
  a_no_idle_rvalid: assert property (@(posedge clk) disable iff (rst)
    !((state == IDLE) && bus.mem_rvalid));

  // Burst length must be a power of two (rlen = 2^k - 1).
  a_rlen_legal: assert property (@(posedge clk) disable iff (rst)
    bus.req_ack |-> ((bus.req_rlen & (bus.req_rlen + 5'd1)) == 5'd0));
`endif

endmodule
`default_nettype wire

// File: doc/icache_burst_reader.md
# icache_burst_reader

Line-fill read engine that sits directly downstream of the instruction cache's read-only memory master port. It accepts one burst request (word address plus length), acknowledges it, and issues the burst as single-word pipelined reads to a simple memory port. It keeps a bounded number of reads outstanding and returns the words to the cache in line order, starting at offset 0 of the line. This ordering matches the cache's internal word counter.

## Interface
Parameters:
- MAX_OUTSTANDING, 4: maximum memory reads accepted but not yet returned; must be ≥1.
- OUTSTANDING_W, $clog2(MAX_OUTSTANDING+1): derived width of the outstanding counter; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_request  in  1  burst request, held until acked
- req_addr  in  30  word address (byte address [31:2]), any word in the line
- req_rlen  in  5  beats minus one; must be 2^k−1 (0,1,3,7,15,31)
- req_ack  out  1  one-cycle acceptance pulse
- req_rvalid  out  1  returned word valid
- req_rdata  out  32  returned word
- mem_read  out  1  read request to memory
- mem_addr  out  30  word address of the read
- mem_ready  in  1  memory accepts the read when mem_read & mem_ready
- mem_rvalid  in  1  read data valid; responses arrive in issue order
- mem_rdata  in  32  read data
- busy  out  1  high whenever the FSM is not IDLE

## Operation
- FSM states are IDLE and BURST.
- IDLE:
  - req_ack = req_request, combinational.
  - On ack, latch the following and go to BURST:
    - base = req_addr & ~{25'b0, req_rlen}
    - last_idx = req_rlen
  - Clear issue_idx, recv_idx and outstanding.
- BURST, issue side:
  - mem_read = ~issue_done & (outstanding < MAX_OUTSTANDING).
  - mem_addr = base | {25'b0, issue_idx}.
  - On accept: issue_idx += 1.
  - issue_done sets when the accept occurs with issue_idx == last_idx.
- BURST, return side, on mem_rvalid:
  - Register mem_rdata into req_rdata.
  - Pulse req_rvalid on the next cycle.
  - recv_idx += 1.
- Outstanding counter:
  - +1 on accept, −1 on mem_rvalid.
  - Both in the same cycle → unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- BURST → IDLE on the cycle mem_rvalid arrives with recv_idx == last_idx.
  - The final req_rvalid appears in the first IDLE cycle.
  - A new req_ack may occur in that same cycle.
- mem_rvalid while IDLE is dropped and not forwarded; a simulation assertion flags it.
- Only the low 5 bits of req_addr are masked; bits [29:5] pass through from req_addr.
- Index counters are 5 bits wide; a 32-beat burst ends exactly at index 31, so the counters never wrap within a burst.
- req_rlen that is not 2^k−1 is illegal; a simulation assertion flags it and behaviour is unspecified.

## Timing
- Reset values:
  - State IDLE.
  - req_ack = 0 while req_request = 0; req_ack is combinational and is only gated by state.
  - req_rvalid = 0, req_rdata = 0.
  - mem_read = 0, mem_addr = 0, busy = 0.
  - All counters 0.
- Reset mid-burst: the next cycle is IDLE with outputs at reset values, and returning data is discarded. The memory shares rst, so no stale responses follow.
- First mem_read is asserted the cycle after req_ack.
- Read latency, with mem_ready = 1 and memory latency L cycles from accept to mem_rvalid:
  - First req_rvalid is at ack + 2 + L.
  - Sustained throughput is one word per cycle when MAX_OUTSTANDING ≥ L + 1.
- req_ack is never asserted in BURST. Exactly one ack is issued per burst.
- req_rvalid count per burst is exactly rlen + 1, in address order base … base + rlen.

## Test plan
- Basic burst: req_addr=0x105, rlen=7, mem_ready=1, L=1, mem_rdata=addr^0xA5A5_0000 → exactly one ack cycle; mem_addr 0x100..0x107, each issued once; 8 req_rvalid with data 0xA5A5_0100..0xA5A5_0107 in order; busy low after the last rvalid.
- Backpressure: same request, mem_ready toggled pseudo-randomly (50%) → identical address and data sequence, no duplicate or skipped address, mem_addr stable while mem_read & ~mem_ready.
- Outstanding limit: MAX_OUTSTANDING=4, L=6, rlen=15 → outstanding peaks at 4; mem_read drops after the 4th accept until the first mem_rvalid; all 16 words are returned in order.
- Single beat: req_addr=0x3FFF_FFFF, rlen=0 → one read at 0x3FFF_FFFF; req_rvalid at ack+3 with L=1; back to IDLE.
- Reset mid-burst: rlen=7, rst pulsed after the 3rd req_rvalid → all outputs 0 the next cycle; a new request req_addr=0x208, rlen=3 then reads 0x208..0x20B correctly.
- Back-to-back: req_request held high → second ack coincides with the final req_rvalid of the first burst; the second burst's first mem_read comes on the following cycle; no data interleaving.
